// File: rtl/trng_health_test.sv
// rtl/trng_health_test.sv - entropy source health monitor (RCT + APT) gating raw samples downstream
// Optional TRNG_HEALTH_MAXRUN_EN adds o_max_run, the longest repetition run seen since reset.
module trng_health_test #(
  parameter int SRC_WIDTH       = 32,
  parameter int RCT_CUTOFF      = 32,
  parameter int APT_WINDOW      = 512,
  parameter int APT_CUTOFF      = 410,
  parameter int STARTUP_WINDOWS = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic [SRC_WIDTH-1:0] i_dat,
  output logic                 o_valid,
  output logic [SRC_WIDTH-1:0] o_dat,
  output logic                 o_ok,
  output logic                 o_alarm,
  output logic [1:0]           o_alarm_src
`ifdef TRNG_HEALTH_MAXRUN_EN
  ,
  output logic [$clog2(RCT_CUTOFF+1)-1:0] o_max_run
`endif
);

  localparam int RUN_W   = $clog2(RCT_CUTOFF + 1);
  localparam int WPOS_W  = $clog2(APT_WINDOW);
  localparam int MATCH_W = $clog2(APT_CUTOFF + 1);
  localparam int WIN_W   = $clog2(STARTUP_WINDOWS + 1);

  typedef enum logic [1:0] {ST_STARTUP, ST_RUN, ST_ALARM} state_t;

  state_t               state_q, state_d;
  logic                 seen_q, seen_d;
  logic                 last_q, last_d;
  logic [RUN_W-1:0]     run_q, run_d;
  logic [WPOS_W-1:0]    wpos_q, wpos_d;
  logic                 ref_q, ref_d;
  logic [MATCH_W-1:0]   match_q, match_d;
  logic [WIN_W-1:0]     win_cnt_q, win_cnt_d;
  logic                 valid_q, valid_d;
  logic [SRC_WIDTH-1:0] dat_q, dat_d;
  logic [1:0]           src_q, src_d;
  logic [RUN_W-1:0]     max_run_q, max_run_d;

  logic                 b;
  logic                 rct_alarm;
  logic                 apt_alarm;
  logic                 win_done;

  always_comb begin
    state_d   = state_q;
    seen_d    = seen_q;
    last_d    = last_q;
    run_d     = run_q;
    wpos_d    = wpos_q;
    ref_d     = ref_q;
    match_d   = match_q;
    win_cnt_d = win_cnt_q;
    valid_d   = 1'b0;
    dat_d     = dat_q;
    src_d     = src_q;
    max_run_d = max_run_q;
    b         = ^i_dat;
    rct_alarm = 1'b0;
    apt_alarm = 1'b0;
    win_done  = 1'b0;

    // ALARM freezes everything until reset, so samples only matter outside it
    if (i_valid && state_q != ST_ALARM) begin
      seen_d = 1'b1;
      last_d = b;
      if (seen_q && b == last_q) begin
        run_d = run_q + RUN_W'(1);
      end else begin
        run_d = RUN_W'(1);
      end
      rct_alarm = (run_d == RUN_W'(RCT_CUTOFF));
      if (run_d > max_run_q) begin
        max_run_d = run_d;
      end

      if (wpos_q == '0) begin
        ref_d   = b;
        match_d = MATCH_W'(1);
      end else if (b == ref_q) begin
        match_d = match_q + MATCH_W'(1);
      end
      apt_alarm = (match_d == MATCH_W'(APT_CUTOFF));
      wpos_d    = wpos_q + WPOS_W'(1);
      win_done  = (wpos_q == WPOS_W'(APT_WINDOW - 1));

      if (rct_alarm || apt_alarm) begin
        state_d = ST_ALARM;
        src_d   = src_q | {apt_alarm, rct_alarm};
      end else if (state_q == ST_STARTUP) begin
        if (win_done) begin
          win_cnt_d = win_cnt_q + WIN_W'(1);
          if (win_cnt_q == WIN_W'(STARTUP_WINDOWS - 1)) begin
            state_d = ST_RUN;
          end
        end
      end else begin
        valid_d = 1'b1;
        dat_d   = i_dat;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_STARTUP;
      seen_q    <= 1'b0;
      last_q    <= 1'b0;
      run_q     <= '0;
      wpos_q    <= '0;
      ref_q     <= 1'b0;
      match_q   <= '0;
      win_cnt_q <= '0;
      valid_q   <= 1'b0;
      dat_q     <= '0;
      src_q     <= 2'b00;
      max_run_q <= '0;
    end else begin
      state_q   <= state_d;
      seen_q    <= seen_d;
      last_q    <= last_d;
      run_q     <= run_d;
      wpos_q    <= wpos_d;
      ref_q     <= ref_d;
      match_q   <= match_d;
      win_cnt_q <= win_cnt_d;
      valid_q   <= valid_d;
      dat_q     <= dat_d;
      src_q     <= src_d;
      max_run_q <= max_run_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_dat       = dat_q;
  assign o_ok        = (state_q == ST_RUN);
  assign o_alarm     = (state_q == ST_ALARM);
  assign o_alarm_src = src_q;

`ifdef TRNG_HEALTH_MAXRUN_EN
  assign o_max_run = max_run_q;
`else
  logic unused_max_run;
  assign unused_max_run = ^max_run_q;
`endif

endmodule
